// File: rtl/stack_cpu_pkg.sv
// Shared encodings for the stack-machine sequencer:
// opcodes, FSM states and instruction field positions.
package stack_cpu_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_ADD   = 3'd1,
    OP_NAND  = 3'd2,
    OP_STORE = 3'd3,
    OP_JMP   = 3'd4,
    OP_JZ    = 3'd5,
    OP_JN    = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_ARG    = 3'd1,
    S_POP_A  = 3'd2,
    S_LOAD_A = 3'd3,
    S_POP_B  = 3'd4,
    S_LOAD_B = 3'd5,
    S_EXEC   = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 5;
  localparam int IND_POS = 4;

  function automatic logic [1:0] pops_needed(opcode_e op);
    case (op)
      OP_ADD, OP_NAND: return 2'd2;
      OP_STORE:        return 2'd1;
      default:         return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Mirrors the datapath stack occupancy and flags
// instructions that would under- or overflow it.
module stack_depth_tracker #(
  parameter int COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] need_pops,
  input  logic       need_room,
  output logic       underflow,
  output logic       overflow
);

  localparam int DW = $clog2(COUNT + 1);

  logic [DW-1:0] depth;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
    end else begin
      case ({push, pop})
        2'b10:   depth <= depth + DW'(1);
        2'b01:   depth <= depth - DW'(1);
        default: depth <= depth;
      endcase
    end
  end

  always_comb begin
    underflow = depth < DW'(need_pops);
    overflow  = need_room && (depth >= DW'(COUNT));
  end

endmodule

// File: rtl/stack_cpu_controller.sv
// Fetch/decode sequencer driving the stack datapath
// one control step per clock.
import stack_cpu_pkg::*;

module stack_cpu_controller #(
  parameter int WORD_RANGE       = 8,
  parameter int STACK_WORD_COUNT = 8,
  parameter int FLAGS_COUNT      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [WORD_RANGE-1:0]  prog_addr,
  input  logic [WORD_RANGE-1:0]  prog_data,
  output logic [WORD_RANGE-1:0]  dp_data_in,
  input  logic [WORD_RANGE-1:0]  dp_data_out,
  input  logic [FLAGS_COUNT-1:0] dp_flags,
  output logic                   cache_a_b_not,
  output logic                   is_data_indirect,
  output logic                   alu_op,
  output logic                   pop_operand,
  output logic                   push_result,
  output logic                   write_mem_result,
  output logic [WORD_RANGE-1:0]  write_address,
  output logic                   halted,
  output logic                   error
);

  localparam logic [WORD_RANGE-1:0] ONE = WORD_RANGE'(1);

  state_e                state, state_n;
  logic [WORD_RANGE-1:0] pc, pc_n;
  logic [3:0]            ir, ir_n;
  logic [WORD_RANGE-1:0] arg, arg_n;
  logic [WORD_RANGE-1:0] pop_q, pop_n;
  logic [WORD_RANGE-1:0] b_hold, b_hold_n;
  logic                  zflag, zflag_n;
  logic                  nflag, nflag_n;
  logic                  halted_n, error_n;

  opcode_e               cur_op, fetch_op;
  logic                  cur_ind, is_nand, is_bin;
  logic                  f_bin, f_halt;
  logic [WORD_RANGE-1:0] load_b_val;
  logic                  underflow, overflow;

  assign cur_op   = opcode_e'(ir[3:1]);
  assign cur_ind  = ir[0];
  assign fetch_op = opcode_e'(prog_data[OP_HI:OP_LO]);
  assign is_nand  = cur_op == OP_NAND;
  assign is_bin   = (cur_op == OP_ADD) || is_nand;
  assign f_bin    = (fetch_op == OP_ADD) ||
                    (fetch_op == OP_NAND);
  assign f_halt   = fetch_op == OP_HALT;

  stack_depth_tracker #(
    .COUNT(STACK_WORD_COUNT)
  ) u_depth (
    .clk       (clk),
    .reset     (reset),
    .push      (push_result),
    .pop       (pop_operand),
    .need_pops (pops_needed(fetch_op)),
    .need_room (fetch_op == OP_PUSH),
    .underflow (underflow),
    .overflow  (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      arg    <= '0;
      pop_q  <= '0;
      b_hold <= '0;
      zflag  <= 1'b0;
      nflag  <= 1'b0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      arg    <= arg_n;
      pop_q  <= pop_n;
      b_hold <= b_hold_n;
      zflag  <= zflag_n;
      nflag  <= nflag_n;
      halted <= halted_n;
      error  <= error_n;
    end
  end

  always_comb begin
    state_n          = state;
    pc_n             = pc;
    ir_n             = ir;
    arg_n            = arg;
    pop_n            = pop_q;
    b_hold_n         = b_hold;
    zflag_n          = zflag;
    nflag_n          = nflag;
    halted_n         = halted;
    error_n          = error;
    load_b_val       = is_bin ? pop_q : '0;
    prog_addr        = pc;
    // cache_b reloads every non-LOAD_A cycle, so keep feeding it its value
    dp_data_in       = b_hold;
    cache_a_b_not    = 1'b0;
    is_data_indirect = 1'b0;
    alu_op           = 1'b0;
    pop_operand      = 1'b0;
    push_result      = 1'b0;
    write_mem_result = 1'b0;
    write_address    = '0;

    case (state)
      S_FETCH: begin
        ir_n = prog_data[OP_HI:IND_POS];
        pc_n = pc + ONE;
        if (underflow || overflow) begin
          state_n  = S_HALT;
          halted_n = 1'b1;
          error_n  = 1'b1;
        end else begin
          unique case (1'b1)
            f_bin:   state_n = S_POP_A;
            f_halt: begin
              state_n  = S_HALT;
              halted_n = 1'b1;
            end
            default: state_n = S_ARG;
          endcase
        end
      end

      S_ARG: begin
        arg_n   = prog_data;
        pc_n    = pc + ONE;
        state_n = S_FETCH;
        case (cur_op)
          OP_PUSH:  state_n = S_LOAD_A;
          OP_STORE: state_n = S_POP_A;
          OP_JMP:   pc_n = prog_data;
          OP_JZ:    if (zflag) pc_n = prog_data;
          OP_JN:    if (nflag) pc_n = prog_data;
          default: begin
            state_n  = S_HALT;
            halted_n = 1'b1;
            error_n  = 1'b1;
          end
        endcase
      end

      S_POP_A: begin
        pop_operand = 1'b1;
        pop_n       = dp_data_out;
        state_n     = S_LOAD_A;
      end

      S_LOAD_A: begin
        cache_a_b_not = 1'b1;
        alu_op        = is_nand;
        if (cur_op == OP_PUSH) begin
          dp_data_in       = arg;
          is_data_indirect = cur_ind;
        end else begin
          dp_data_in = pop_q;
        end
        state_n = is_bin ? S_POP_B : S_LOAD_B;
      end

      S_POP_B: begin
        pop_operand = 1'b1;
        alu_op      = is_nand;
        pop_n       = dp_data_out;
        state_n     = S_LOAD_B;
      end

      S_LOAD_B: begin
        alu_op     = is_nand;
        dp_data_in = load_b_val;
        b_hold_n   = load_b_val;
        state_n    = S_EXEC;
      end

      S_EXEC: begin
        alu_op  = is_nand;
        zflag_n = dp_flags[0];
        nflag_n = dp_flags[1];
        state_n = S_FETCH;
        case (cur_op)
          OP_STORE: begin
            write_mem_result = 1'b1;
            write_address    = arg;
          end
          OP_PUSH, OP_ADD, OP_NAND: push_result = 1'b1;
          default: begin
            state_n  = S_HALT;
            halted_n = 1'b1;
            error_n  = 1'b1;
          end
        endcase
      end

      S_HALT: begin
        state_n  = S_HALT;
        halted_n = 1'b1;
      end

      default: begin
        state_n  = S_HALT;
        halted_n = 1'b1;
        error_n  = 1'b1;
      end
    endcase
  end

endmodule
